// File: rtl/vector_regfile_sb.sv
// Vector register file with two registered read ports and one lane-masked
// write port. It adds a write-first bypass, a hardware sweep-clear after reset
// or on request, and a per-register pending-write scoreboard for issue-stage
// hazard checks.
//
// Handshake: re is a request with no back-pressure. A request accepted at
// edge N (re=1 while idle) produces data1/data2 with rd_valid=1 for exactly
// the cycle after edge N. While busy=1, re, we and reserve_valid are dropped,
// rd_valid stays 0 and the data outputs hold their last value.
module vector_regfile_sb #(
    parameter  int NUM_REGS = 32,
    parameter  int LANES    = 4,
    parameter  int DATA_W   = 32,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int VW       = LANES * DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re,
    input  logic [AW-1:0] read1,
    input  logic [AW-1:0] read2,
    output logic [VW-1:0] data1,
    output logic [VW-1:0] data2,
    output logic          rd_valid,
    input  logic [LANES-1:0] we,
    input  logic [AW-1:0] write_addr,
    input  logic [VW-1:0] write_vector,
    input  logic          reserve_valid,
    input  logic [AW-1:0] reserve_addr,
    output logic          pending1,
    output logic          pending2,
    input  logic          clear_req,
    output logic          busy,
    output logic          o_dbg_state
);

    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_clr_ptr;
    logic [AW-1:0]       w_clr_ptr_nxt;
    logic [VW-1:0]       r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic [VW-1:0]       r_data1;
    logic [VW-1:0]       r_data2;
    logic                r_rd_valid;

    logic                w_idle;
    logic                w_wr_ok;
    logic                w_wr_to_zero;
    logic                w_wr_any;
    logic                w_rsv_en;
    logic                w_rd_en;
    logic [VW-1:0]       w_rd1;
    logic [VW-1:0]       w_rd2;

    // The request-clear edge drops its own write and reservation.
    assign w_idle       = (r_state == S_IDLE);
    assign w_wr_ok      = w_idle && !clear_req;
    assign w_wr_to_zero = ZR && (write_addr == '0);
    assign w_wr_any     = w_wr_ok && (|we) && !w_wr_to_zero;
    assign w_rsv_en     = w_wr_ok && reserve_valid && !(ZR && (reserve_addr == '0));
    assign w_rd_en      = w_idle && re;

    assign data1       = r_data1;
    assign data2       = r_data2;
    assign rd_valid    = r_rd_valid;
    assign busy        = (r_state == S_CLEAR);
    assign pending1    = r_pending[read1];
    assign pending2    = r_pending[read2];
    assign o_dbg_state = r_state;

    // State register and sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next state: sweep one register per edge, leave after the last one.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            S_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == AW'(NUM_REGS - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_ptr_nxt = '0;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Storage: the sweep zeroes one register per edge, otherwise lane-masked writes.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_ok && !w_wr_to_zero) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    r_mem[write_addr][i*DATA_W +: DATA_W] <= write_vector[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read mux with write-first lane bypass; the zero register overrides everything.
    always_comb begin
        w_rd1 = r_mem[read1];
        w_rd2 = r_mem[read2];
        for (int i = 0; i < LANES; i++) begin
            if (w_wr_ok && we[i] && (write_addr == read1)) begin
                w_rd1[i*DATA_W +: DATA_W] = write_vector[i*DATA_W +: DATA_W];
            end
            if (w_wr_ok && we[i] && (write_addr == read2)) begin
                w_rd2[i*DATA_W +: DATA_W] = write_vector[i*DATA_W +: DATA_W];
            end
        end
        if (ZR && (read1 == '0)) begin
            w_rd1 = '0;
        end
        if (ZR && (read2 == '0)) begin
            w_rd2 = '0;
        end
    end

    // Registered read outputs; data holds between accepted requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data1    <= '0;
            r_data2    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_data1 <= w_rd1;
                r_data2 <= w_rd2;
            end
        end
    end

    // Pending scoreboard: a write clears, a reservation sets, and set wins on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_idle && clear_req) begin
            r_pending <= '0;
        end else begin
            if (w_wr_any) begin
                r_pending[write_addr] <= 1'b0;
            end
            if (w_rsv_en) begin
                r_pending[reserve_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_regfile_sb.sv
// Directed bench for vector_regfile_sb: one default instance and one with the
// hardwired-zero register. Read responses go through expected queues checked
// by a monitor; status outputs are checked inline.
module tb_vector_regfile_sb;

    localparam int VW = 128;

    logic            clk;
    logic            rst_n;
    logic            re, reserve_valid, clear_req;
    logic [4:0]      read1, read2, write_addr, reserve_addr;
    logic [3:0]      we;
    logic [VW-1:0]   write_vector;
    logic [VW-1:0]   data1, data2;
    logic            rd_valid, pending1, pending2, busy, dbg;

    logic            z_re, z_reserve_valid, z_clear_req;
    logic [4:0]      z_read1, z_read2, z_write_addr, z_reserve_addr;
    logic [3:0]      z_we;
    logic [VW-1:0]   z_write_vector;
    logic [VW-1:0]   z_data1, z_data2;
    logic            z_rd_valid, z_pending1, z_pending2, z_busy, z_dbg;

    logic [2*VW-1:0] exp_q[$];
    logic [2*VW-1:0] exp_zq[$];
    int              n_vec;
    int              n_err;

    vector_regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .re(re), .read1(read1), .read2(read2),
        .data1(data1), .data2(data2), .rd_valid(rd_valid), .we(we),
        .write_addr(write_addr), .write_vector(write_vector),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .pending1(pending1), .pending2(pending2), .clear_req(clear_req),
        .busy(busy), .o_dbg_state(dbg)
    );

    vector_regfile_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .re(z_re), .read1(z_read1), .read2(z_read2),
        .data1(z_data1), .data2(z_data2), .rd_valid(z_rd_valid), .we(z_we),
        .write_addr(z_write_addr), .write_vector(z_write_vector),
        .reserve_valid(z_reserve_valid), .reserve_addr(z_reserve_addr),
        .pending1(z_pending1), .pending2(z_pending2), .clear_req(z_clear_req),
        .busy(z_busy), .o_dbg_state(z_dbg)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VW-1:0] vec4(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] m, input logic [VW-1:0] v);
        write_addr   = a;
        we           = m;
        write_vector = v;
        tick();
        we           = '0;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [VW-1:0] e1, input logic [VW-1:0] e2);
        read1 = a1;
        read2 = a2;
        re    = 1'b1;
        exp_q.push_back({e1, e2});
        tick();
        re    = 1'b0;
    endtask

    task automatic do_reserve(input logic [4:0] a);
        reserve_addr  = a;
        reserve_valid = 1'b1;
        tick();
        reserve_valid = 1'b0;
    endtask

    // monitor: pop and compare whenever either instance presents read data
    initial begin
        logic [2*VW-1:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: got %h expected no response", {data1, data2});
                end else begin
                    e = exp_q.pop_front();
                    if ({data1, data2} !== e) begin
                        n_err++;
                        $display("FAIL rd_data: got %h expected %h", {data1, data2}, e);
                    end
                end
            end
            if (z_rd_valid === 1'b1) begin
                n_vec++;
                if (exp_zq.size() == 0) begin
                    n_err++;
                    $display("FAIL zrd_unexpected: got %h expected no response", {z_data1, z_data2});
                end else begin
                    e = exp_zq.pop_front();
                    if ({z_data1, z_data2} !== e) begin
                        n_err++;
                        $display("FAIL zrd_data: got %h expected %h", {z_data1, z_data2}, e);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [VW-1:0] v7, v7b, va, vb, v12, v4, v55;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        re = 0; reserve_valid = 0; clear_req = 0; we = '0;
        read1 = '0; read2 = '0; write_addr = '0; reserve_addr = '0; write_vector = '0;
        z_re = 0; z_reserve_valid = 0; z_clear_req = 0; z_we = '0;
        z_read1 = '0; z_read2 = '0; z_write_addr = '0; z_reserve_addr = '0; z_write_vector = '0;
        v7  = vec4(32'h4, 32'h3, 32'h2, 32'h1);
        v7b = vec4(32'h4, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
        va  = vec4(32'hA, 32'hA, 32'hA, 32'hA);
        vb  = vec4(32'hA, 32'hA, 32'hB, 32'hA);
        v12 = vec4(32'h1, 32'h2, 32'h3, 32'h4);
        v4  = vec4(32'h9, 32'h9, 32'h9, 32'h9);
        v55 = vec4(32'h55, 32'h55, 32'h55, 32'h55);
        repeat (3) tick();

        // reset sweep with re held high
        chk1("rst_busy", busy, 1'b1);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chkv("rst_data1", data1, '0);
        read1 = 5'd5; read2 = 5'd31; re = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk1("sweep_busy", busy, (k < 32));
            chk1("sweep_rd_valid", rd_valid, 1'b0);
        end
        chk1("dbg_idle", dbg, 1'b1);
        exp_q.push_back({128'h0, 128'h0});
        tick();
        re = 1'b0;
        tick();
        chk1("rd_valid_drop", rd_valid, 1'b0);

        // full and masked writes
        do_write(5'd7, 4'b1111, v7);
        do_read(5'd7, 5'd7, v7, v7);
        tick();
        chk1("hold_rd_valid", rd_valid, 1'b0);
        chkv("hold_data1", data1, v7);
        do_write(5'd7, 4'b0101, {4{32'hFFFF_FFFF}});
        do_read(5'd7, 5'd5, v7b, '0);

        // write-first bypass on both ports, masked lanes keep stored data
        do_write(5'd3, 4'b1111, va);
        write_addr = 5'd3; we = 4'b0010;
        write_vector = vec4(32'hDEAD, 32'hDEAD, 32'hB, 32'hDEAD);
        read1 = 5'd3; read2 = 5'd3; re = 1'b1;
        exp_q.push_back({vb, vb});
        tick();
        re = 1'b0; we = '0;
        do_read(5'd3, 5'd7, vb, v7b);

        // pending scoreboard
        do_reserve(5'd9);
        read1 = 5'd9; read2 = 5'd10;
        #1;
        chk1("pend_set", pending1, 1'b1);
        chk1("pend_other", pending2, 1'b0);
        reserve_addr = 5'd9; reserve_valid = 1'b1;
        write_addr = 5'd9; we = 4'b0001; write_vector = '0;
        #1;
        chk1("pend_no_comb_clear", pending1, 1'b1);
        tick();
        reserve_valid = 1'b0; we = '0;
        chk1("pend_set_wins", pending1, 1'b1);
        do_write(5'd9, 4'b0001, vec4(0, 0, 0, 32'h99));
        chk1("pend_write_clears", pending1, 1'b0);
        reserve_addr = 5'd9; reserve_valid = 1'b1; we = '0;
        tick();
        reserve_valid = 1'b0;
        chk1("pend_we0_keeps", pending1, 1'b1);

        // requested sweep-clear; the clear_req edge drops its write and reservation
        do_write(5'd12, 4'b1111, v12);
        do_read(5'd12, 5'd12, v12, v12);
        do_reserve(5'd20);
        read1 = 5'd20;
        #1;
        chk1("pend20_set", pending1, 1'b1);
        clear_req = 1'b1;
        write_addr = 5'd12; we = 4'b1111; write_vector = {4{32'hFFFF_FFFF}};
        reserve_addr = 5'd21; reserve_valid = 1'b1;
        tick();
        clear_req = 1'b0; we = '0; reserve_valid = 1'b0;
        read1 = 5'd20; read2 = 5'd21;
        #1;
        chk1("clr_pend20", pending1, 1'b0);
        chk1("clr_pend21_dropped", pending2, 1'b0);
        read1 = 5'd9;
        #1;
        chk1("clr_pend9", pending1, 1'b0);
        chk1("clr_busy", busy, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            if (k == 20) begin
                write_addr = 5'd2; we = 4'b1111; write_vector = va; re = 1'b1;
            end
            tick();
            we = '0; re = 1'b0;
            clear_req = (k == 5);
            chk1("clr_sweep_busy", busy, (k < 32));
        end
        clear_req = 1'b0;
        chkv("clr_hold_data1", data1, v12);
        do_read(5'd12, 5'd2, '0, '0);
        do_read(5'd7, 5'd3, '0, '0);

        // reset in the middle of a sweep restarts it from the beginning
        do_write(5'd4, 4'b1111, v4);
        do_read(5'd4, 5'd4, v4, v4);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b1);
        chk1("midrst_rd_valid", rd_valid, 1'b0);
        chkv("midrst_data1", data1, '0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk1("restart_busy", busy, (k < 32));
        end
        do_read(5'd4, 5'd7, '0, '0);

        // hardwired-zero register instance
        z_write_addr = 5'd0; z_we = 4'b1111; z_write_vector = v55;
        tick();
        z_we = '0;
        z_read1 = 5'd0; z_read2 = 5'd0; z_re = 1'b1;
        exp_zq.push_back({128'h0, 128'h0});
        tick();
        z_re = 1'b0;
        z_write_addr = 5'd0; z_we = 4'b1111; z_write_vector = v55;
        z_read1 = 5'd0; z_read2 = 5'd0; z_re = 1'b1;
        exp_zq.push_back({128'h0, 128'h0});
        tick();
        z_write_addr = 5'd1; z_we = 4'b1111; z_write_vector = v55;
        z_read1 = 5'd1; z_read2 = 5'd0; z_re = 1'b1;
        exp_zq.push_back({v55, 128'h0});
        tick();
        z_we = '0; z_re = 1'b0;
        z_reserve_addr = 5'd0; z_reserve_valid = 1'b1;
        tick();
        z_reserve_addr = 5'd1;
        tick();
        z_reserve_valid = 1'b0;
        z_read1 = 5'd0; z_read2 = 5'd1;
        #1;
        chk1("zero_pend0", z_pending1, 1'b0);
        chk1("zero_pend1", z_pending2, 1'b1);

        repeat (3) tick();
        chk1("exp_q_drained", (exp_q.size() == 0), 1'b1);
        chk1("exp_zq_drained", (exp_zq.size() == 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
